// File: rtl/multi_button_debouncer_pkg.sv
// Shared constants for the push-button debouncer: board timing, button
// indices and the per-channel auto-repeat state encoding.
package multi_button_debouncer_pkg;

    localparam int CLK_FREQ_HZ          = 100_000_000;
    localparam int DEBOUNCE_MS          = 10;
    localparam int STABLE_COUNT_DEFAULT = (CLK_FREQ_HZ / 1000) * DEBOUNCE_MS;

    // Nexys A7 button positions within button_in
    localparam int BTN_U = 0;
    localparam int BTN_D = 1;
    localparam int BTN_L = 2;
    localparam int BTN_R = 3;
    localparam int BTN_C = 4;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_DELAY = 2'd1,
        REPEAT     = 2'd2
    } repeat_state_t;

endpackage

// File: rtl/multi_button_debouncer_channel.sv
// One debounce channel: synchroniser, stability counter, registered
// press/release pulses and an optional auto-repeat state machine.
module debounce_channel
    import multi_button_debouncer_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_COUNT  = STABLE_COUNT_DEFAULT,
    parameter int REPEAT_EN     = 0,
    parameter int REPEAT_DELAY  = 50_000_000,
    parameter int REPEAT_PERIOD = 10_000_000,
    parameter int CNT_W         = 26
) (
    input  logic clk,
    input  logic reset,
    input  logic button_in,
    output logic button_out,
    output logic button_press,
    output logic button_release
);

    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_COUNT - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic [CNT_W-1:0]       db_cnt_reg;
    logic                   level_reg;
    logic                   press_reg;
    logic                   release_reg;
    logic                   s;
    logic                   flip;
    logic                   rise;
    logic                   fall;

    repeat_state_t          state_reg;
    repeat_state_t          state_next;
    logic [CNT_W-1:0]       rep_cnt_reg;
    logic [CNT_W-1:0]       rep_cnt_next;
    logic                   repeat_fire;
    logic                   press_next;
    logic                   release_next;

    assign s    = sync_reg[SYNC_STAGES-1];
    assign flip = (s != level_reg) && (db_cnt_reg == STABLE_LAST);
    assign rise = flip && s;
    assign fall = flip && !s;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], button_in};
        end
    end

    // Any cycle agreeing with the current level restarts the stability window
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            db_cnt_reg <= '0;
            level_reg  <= 1'b0;
        end else if (s == level_reg) begin
            db_cnt_reg <= '0;
        end else if (flip) begin
            level_reg  <= s;
            db_cnt_reg <= '0;
        end else begin
            db_cnt_reg <= db_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            rep_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            rep_cnt_reg <= rep_cnt_next;
        end
    end

    // The press phase is folded into the IDLE->WAIT_DELAY transition.
    always_comb begin
        state_next   = state_reg;
        rep_cnt_next = rep_cnt_reg;
        if (REPEAT_EN == 0) begin
            state_next   = IDLE;
            rep_cnt_next = '0;
        end else if (fall) begin
            state_next   = IDLE;
            rep_cnt_next = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    rep_cnt_next = '0;
                    if (rise) begin
                        state_next = WAIT_DELAY;
                    end
                end
                WAIT_DELAY: begin
                    if (rep_cnt_reg == DELAY_LAST) begin
                        state_next   = REPEAT;
                        rep_cnt_next = '0;
                    end else begin
                        rep_cnt_next = rep_cnt_reg + 1'b1;
                    end
                end
                REPEAT: begin
                    if (rep_cnt_reg == PERIOD_LAST) begin
                        rep_cnt_next = '0;
                    end else begin
                        rep_cnt_next = rep_cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_next   = IDLE;
                    rep_cnt_next = '0;
                end
            endcase
        end
    end

    // A debounced fall suppresses any repeat pulse due in the same cycle
    always_comb begin
        repeat_fire = 1'b0;
        if ((REPEAT_EN != 0) && !fall) begin
            case (state_reg)
                WAIT_DELAY: repeat_fire = (rep_cnt_reg == DELAY_LAST);
                REPEAT:     repeat_fire = (rep_cnt_reg == PERIOD_LAST);
                default:    repeat_fire = 1'b0;
            endcase
        end
        press_next   = rise || repeat_fire;
        release_next = fall;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            press_reg   <= 1'b0;
            release_reg <= 1'b0;
        end else begin
            press_reg   <= press_next;
            release_reg <= release_next;
        end
    end

    assign button_out     = level_reg;
    assign button_press   = press_reg;
    assign button_release = release_reg;

endmodule

// File: rtl/multi_button_debouncer.sv
// N independent button debounce channels with press/release pulses and
// optional auto-repeat.
module multi_button_debouncer
    import multi_button_debouncer_pkg::*;
#(
    parameter int NUM_BTNS      = 5,
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_COUNT  = STABLE_COUNT_DEFAULT,
    parameter int REPEAT_EN     = 0,
    parameter int REPEAT_DELAY  = 50_000_000,
    parameter int REPEAT_PERIOD = 10_000_000,
    parameter int CNT_W         = 26
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_BTNS-1:0] button_in,
    output logic [NUM_BTNS-1:0] button_out,
    output logic [NUM_BTNS-1:0] button_press,
    output logic [NUM_BTNS-1:0] button_release
);

    generate
        for (genvar gi = 0; gi < NUM_BTNS; gi++) begin : g_chan
            debounce_channel #(
                .SYNC_STAGES  (SYNC_STAGES),
                .STABLE_COUNT (STABLE_COUNT),
                .REPEAT_EN    (REPEAT_EN),
                .REPEAT_DELAY (REPEAT_DELAY),
                .REPEAT_PERIOD(REPEAT_PERIOD),
                .CNT_W        (CNT_W)
            ) u_chan (
                .clk           (clk),
                .reset         (reset),
                .button_in     (button_in[gi]),
                .button_out    (button_out[gi]),
                .button_press  (button_press[gi]),
                .button_release(button_release[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_multi_button_debouncer.sv
// Directed bench: one instance without auto-repeat (a) and one with it (b).
module tb_multi_button_debouncer;

    localparam int NB = 5;

    logic          clk   = 1'b0;
    logic          reset = 1'b0;
    logic [NB-1:0] btn_a = '0;
    logic [NB-1:0] btn_b = '0;
    logic [NB-1:0] out_a, press_a, rel_a;
    logic [NB-1:0] out_b, press_b, rel_b;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int pcnt_a[NB];
    int pcnt_b[NB];
    int rcnt_a[NB];
    int rcnt_b[NB];
    int last_b[NB];
    int rep_q[$];
    int rise_cyc;

    always #5 clk = ~clk;

    multi_button_debouncer #(
        .NUM_BTNS(NB), .SYNC_STAGES(2), .STABLE_COUNT(4), .REPEAT_EN(0),
        .REPEAT_DELAY(10), .REPEAT_PERIOD(3), .CNT_W(8)
    ) dut_a (
        .clk(clk), .reset(reset), .button_in(btn_a),
        .button_out(out_a), .button_press(press_a), .button_release(rel_a)
    );

    multi_button_debouncer #(
        .NUM_BTNS(NB), .SYNC_STAGES(2), .STABLE_COUNT(4), .REPEAT_EN(1),
        .REPEAT_DELAY(10), .REPEAT_PERIOD(3), .CNT_W(8)
    ) dut_b (
        .clk(clk), .reset(reset), .button_in(btn_b),
        .button_out(out_b), .button_press(press_b), .button_release(rel_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic clear_counts();
        for (int i = 0; i < NB; i++) begin
            pcnt_a[i] = 0;
            pcnt_b[i] = 0;
            rcnt_a[i] = 0;
            rcnt_b[i] = 0;
            last_b[i] = -1;
        end
    endtask

    // One clock; outputs sampled 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < NB; i++) begin
            if (press_a[i]) pcnt_a[i]++;
            if (rel_a[i])   rcnt_a[i]++;
            if (press_b[i]) begin
                pcnt_b[i]++;
                last_b[i] = cyc;
            end
            if (rel_b[i])   rcnt_b[i]++;
        end
        if (press_b[1]) rep_q.push_back(cyc);
        check("excl_a", {27'd0, press_a & rel_a}, 32'd0);
        check("excl_b", {27'd0, press_b & rel_b}, 32'd0);
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp_off[9];
        exp_off = '{0, 10, 13, 16, 19, 22, 25, 28, 31};
        clear_counts();

        // Reset held with all buttons pressed
        btn_a = 5'b11111;
        btn_b = 5'b00000;
        reset = 1'b0;
        steps(3);
        check("rst_out_a", {27'd0, out_a}, 32'h00);
        check("rst_press_a", {27'd0, press_a}, 32'h00);
        check("rst_rel_a", {27'd0, rel_a}, 32'h00);
        check("rst_out_b", {27'd0, out_b}, 32'h00);
        reset = 1'b1;
        clear_counts();
        steps(5);
        check("rst_lat_early", {27'd0, out_a}, 32'h00);
        step();
        check("rst_lat_out", {27'd0, out_a}, 32'h1f);
        check("rst_lat_press", {27'd0, press_a}, 32'h1f);
        step();
        check("rst_press_clr", {27'd0, press_a}, 32'h00);
        check("rst_press_cnt", pcnt_a.sum(), 32'd5);
        $display("reset scenario done at cycle %0d", cyc);

        // Release of channel 2
        clear_counts();
        btn_a = 5'b11011;
        steps(5);
        check("rel_early", {27'd0, out_a}, 32'h1f);
        step();
        check("rel_out", {27'd0, out_a}, 32'h1b);
        check("rel_pulse", {27'd0, rel_a}, 32'h04);
        check("rel_no_press", {27'd0, press_a}, 32'h00);
        step();
        check("rel_pulse_clr", {27'd0, rel_a}, 32'h00);
        check("rel_cnt", rcnt_a[2], 32'd1);
        $display("release scenario done at cycle %0d", cyc);

        // Bounce on channel 0, then hold
        btn_a = 5'b00000;
        steps(8);
        clear_counts();
        for (int k = 0; k < 4; k++) begin
            btn_a[0] = (k % 2 == 0);
            steps(2);
        end
        check("bnc_glitch_out", {31'd0, out_a[0]}, 32'd0);
        btn_a[0] = 1'b1;
        steps(5);
        check("bnc_early", {31'd0, out_a[0]}, 32'd0);
        step();
        check("bnc_rise", {31'd0, out_a[0]}, 32'd1);
        check("bnc_press", {27'd0, press_a}, 32'h01);
        steps(12);
        check("bnc_press_cnt", pcnt_a[0], 32'd1);
        $display("bounce scenario done at cycle %0d", cyc);

        // Auto-repeat on channel 1 of instance b
        rep_q.delete();
        clear_counts();
        btn_b[1] = 1'b1;
        steps(6);
        check("rep_rise", {31'd0, out_b[1]}, 32'd1);
        rise_cyc = cyc;
        steps(31);
        check("rep_n", rep_q.size(), 32'd9);
        for (int i = 0; i < 9; i++) begin
            if (i < rep_q.size()) check("rep_off", rep_q[i] - rise_cyc, exp_off[i]);
        end
        btn_b[1] = 1'b0;
        steps(5);
        check("rep_fall_early", {31'd0, out_b[1]}, 32'd1);
        step();
        check("rep_fall_out", {31'd0, out_b[1]}, 32'd0);
        check("rep_rel", {27'd0, rel_b}, 32'h02);
        check("rep_rel_prio", {27'd0, press_b}, 32'h00);
        $display("repeat scenario done at cycle %0d", cyc);

        // Independence of channels 3/4, then reset during WAIT_DELAY
        steps(4);
        clear_counts();
        btn_b[3] = 1'b1;
        steps(2);
        btn_b[4] = 1'b1;
        steps(10);
        check("ind_out", {27'd0, out_b}, 32'h18);
        check("ind_cnt3", pcnt_b[3], 32'd1);
        check("ind_cnt4", pcnt_b[4], 32'd1);
        check("ind_offset", last_b[4] - last_b[3], 32'd2);
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_out_b", {27'd0, out_b}, 32'h00);
        check("mid_rst_out_a", {27'd0, out_a}, 32'h00);
        steps(3);
        check("mid_rst_hold", {27'd0, out_b | press_b | rel_b}, 32'h00);
        reset = 1'b1;
        clear_counts();
        steps(5);
        check("rel_rst_no_pulse_b", pcnt_b.sum(), 32'd0);
        check("rel_rst_no_pulse_a", pcnt_a.sum(), 32'd0);
        step();
        check("requal_press_b", {27'd0, press_b}, 32'h18);
        check("requal_press_a", {27'd0, press_a}, 32'h01);
        check("requal_out_b", {27'd0, out_b}, 32'h18);
        steps(10);
        check("requal_repeat_b", {27'd0, press_b}, 32'h18);
        $display("independence/reset scenario done at cycle %0d", cyc);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/multi_button_debouncer.md
Name: multi_button_debouncer

Overview:
- Parametrised N-channel successor to the single-button debouncer.
- Debounces all Nexys A7 push-buttons (BTNU/BTND/BTNL/BTNR/BTNC) into clean, synchronised levels.
- Adds per-channel one-cycle press/release pulses and optional auto-repeat of the press pulse while a button is held.
- Sits between the board buttons and the snake direction/control logic.

Parameters:
- NUM_BTNS, 5, number of independent channels.
- SYNC_STAGES, 2, input synchroniser flops per channel (min 2).
- STABLE_COUNT, 1000000, cycles the synchronised input must differ from the debounced level before the level flips (10 ms at 100 MHz; min 2).
- REPEAT_EN, 0, 1 enables auto-repeat press pulses while held.
- REPEAT_DELAY, 50000000, cycles from the initial press pulse to the first repeat pulse (min 2).
- REPEAT_PERIOD, 10000000, cycles between subsequent repeat pulses (min 2).
- CNT_W, 26, counter width; must hold max(STABLE_COUNT, REPEAT_DELAY, REPEAT_PERIOD).

Ports:
- clk  input  1  system clock, 100 MHz.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- button_in  input  NUM_BTNS  raw asynchronous button inputs, active-high.
- button_out  output  NUM_BTNS  debounced level per channel.
- button_press  output  NUM_BTNS  one-cycle pulse on debounced rise and on each auto-repeat.
- button_release  output  NUM_BTNS  one-cycle pulse on debounced fall.

Behaviour:
- Reset (reset=0, asynchronous): all synchroniser flops, counters, button_out, button_press and button_release go to 0. Release is synchronous to clk through normal flop behaviour.
- Channels are fully independent; no cross-channel priority.
- Synchroniser: button_in[i] passes through SYNC_STAGES flops; the last stage is "s".
- Debounce counter, each cycle:
  - if s == button_out[i], the counter clears to 0;
  - otherwise the counter increments;
  - when the counter equals STABLE_COUNT-1 while s != button_out[i], button_out[i] takes s on the next edge and the counter clears.
- Latency: if button_in is stable from edge t, button_out changes at edge t + SYNC_STAGES + STABLE_COUNT - 1 (±1 for input sampling phase).
- Bounce: any cycle with s == button_out clears the counter. A glitch shorter than STABLE_COUNT cycles never changes the output.
- Pulses: button_press[i] is registered and high for exactly one cycle, in the same cycle button_out[i] first reads 1. button_release[i] behaves the same way on the first cycle button_out[i] reads 0. Both are never high together on one channel.
- Auto-repeat (REPEAT_EN=1), per-channel state machine:
  - IDLE: button_out=0.
  - PRESS: entered on the debounced rise; the rise pulse fires; the repeat counter clears.
  - WAIT_DELAY: repeat counter increments; at REPEAT_DELAY-1, pulse button_press, clear the counter, go to REPEAT.
  - REPEAT: at REPEAT_PERIOD-1, pulse button_press and clear the counter.
  - Debounced fall from any state: go to IDLE, release pulse fires, no press pulse that cycle (release has priority).
- REPEAT_EN=0: the repeat FSM and counter are tied off and only edge pulses are produced.
- Counters never wrap: every compare-and-clear happens before overflow, given the CNT_W rule.
- Reset asserted mid-debounce or mid-repeat: immediate return to the reset state; no pulse is emitted on reset release even if the button is held. A held button re-qualifies as a fresh press after STABLE_COUNT.

Decomposition:
- Shared constants header: CLK_FREQ_HZ, DEBOUNCE_MS, derived STABLE_COUNT default, button index constants BTN_U/BTN_D/BTN_L/BTN_R/BTN_C, and the repeat FSM state encodings (IDLE, WAIT_DELAY, REPEAT).
- One sub-module, debounce_channel: synchroniser, debounce counter, edge pulses and repeat FSM for a single bit.
- The top generates NUM_BTNS instances.

Test Plan:
- Bench params for all scenarios: NUM_BTNS=5, SYNC_STAGES=2, STABLE_COUNT=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, CNT_W=8.
- Reset: hold reset=0 with button_in=5'b11111 -> all outputs 0; after reset=1, button_out reaches 5'b11111 after 2+4-1 cycles with one press pulse per channel.
- Bounce rejection: toggle button_in[0] 1,0,1,0 every 2 cycles then hold 1 -> button_out[0] rises exactly once, 5 cycles after the final stable edge; exactly one button_press[0] pulse.
- Release: from held, drop button_in[2] to 0 -> button_release[2] high for exactly 1 cycle when button_out[2] falls; no press pulse.
- Auto-repeat (REPEAT_EN=1): hold button_in[1] for 30 cycles after qualify -> press pulses at offsets 0, 10, 13, 16, 19, 22, 25, 28; release pulse on fall.
- Independence and reset mid-operation: press channels 3 and 4 two cycles apart -> pulses offset by 2; assert reset=0 during WAIT_DELAY -> outputs 0 immediately, no pulse at reset release while held, re-press pulse after qualify.
